dct_transpose: RTL and testbench

Transpose buffer between the row (1-D, first pass) DCT and the column (second pass) DCT of the 2-D 8x8 DCT. It accepts one 8-coefficient row per valid beat and emits the block as 8 columns, one per cycle. Ping-pong banks give full streaming throughput with no backpressure. Block, frame and valid sideband travels with the data so the column DCT receives the same framing the row DCT produced.

---
 rtl/dct_transpose.sv | 73 +++++++
 tb/tb_dct_transpose.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dct_transpose.sv
// dct_transpose: ping-pong 8x8 transpose buffer between the row and column DCT passes.
// Rows are written into one bank while the other bank is read out column by column.
module dct_transpose #(
   parameter int W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0][W-1:0] in_data,
   input  logic              in_sob,
   input  logic              in_eob,
   input  logic              in_sof,
   output logic              out_valid,
   output logic [7:0][W-1:0] out_data,
   output logic              out_sob,
   output logic              out_eob,
   output logic              out_sof,
   output logic              out_err
);
   logic [7:0][W-1:0] mem [2][8];
   logic              wbank, rbank, ract, done, bad;
   logic [2:0]        wrow, rcol, row;
   logic [1:0]        full, sof_flag;
   logic [7:0][W-1:0] col;

   always_comb begin
      row  = in_sob ? 3'd0 : wrow;
      ract = full[rbank];
      done = in_valid && row == 3'd7 && in_eob;
      bad  = in_valid && ((in_sob && wrow != 3'd0) || ((row == 3'd7) != in_eob));
      for (int i = 0; i < 8; i++) col[i] = mem[rbank][i][rcol];
   end

   always_ff @(posedge clk)
      if (in_valid) mem[wbank][row] <= in_data;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wbank     <= 1'b0;
         rbank     <= 1'b0;
         wrow      <= 3'd0;
         rcol      <= 3'd0;
         full      <= 2'b00;
         sof_flag  <= 2'b00;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sob   <= 1'b0;
         out_eob   <= 1'b0;
         out_sof   <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         out_err   <= bad;
         out_valid <= ract;
         out_sob   <= ract && rcol == 3'd0;
         out_eob   <= ract && rcol == 3'd7;
         out_sof   <= ract && rcol == 3'd0 && sof_flag[rbank];
         if (in_valid) begin
            wrow <= (row == 3'd7 || in_eob) ? 3'd0 : row + 3'd1;
            if (row == 3'd0) sof_flag[wbank] <= in_sob & in_sof;
            if (done) wbank <= ~wbank;
         end
         if (ract) begin
            out_data <= col;
            rcol     <= rcol + 3'd1;
            if (rcol == 3'd7) begin
               full[rbank] <= 1'b0;
               rbank       <= ~rbank;
            end
         end
         // completing bank is never the one being released, so set after clear
         if (done) full[wbank] <= 1'b1;
      end
endmodule

// File: tb/tb_dct_transpose.sv
// tb_dct_transpose: random and directed stimulus checked against a block-level transpose model.
module tb_dct_transpose;
   localparam int W = 16;
   logic              clk = 1'b0, rst_n = 1'b0;
   logic              in_valid = 1'b0, in_sob = 1'b0, in_eob = 1'b0, in_sof = 1'b0;
   logic [7:0][W-1:0] in_data = '0;
   logic              out_valid, out_sob, out_eob, out_sof, out_err;
   logic [7:0][W-1:0] out_data;

   dct_transpose #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof),
      .out_valid(out_valid), .out_data(out_data), .out_sob(out_sob),
      .out_eob(out_eob), .out_sof(out_sof), .out_err(out_err)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                due;
      logic [7:0][W-1:0] d;
      logic              sob, eob, sof;
   } beat_t;
   beat_t             q[$];
   bit                err_at[int];
   logic [7:0][W-1:0] rows[8];
   int                mcnt = 0, next_free = 0, n_cmp = 0, n_bad = 0;
   bit                msof, ev;

   task automatic chk1(string n, logic a, logic e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at cycle %0d", n, a, e, cyc);
      end
   endtask

   task automatic chkd(string n, logic [7:0][W-1:0] a, logic [7:0][W-1:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at cycle %0d", n, a, e, cyc);
      end
   endtask

   // block-level model: collect rows, emit the transposed block once row 7 closes it
   task automatic model_beat(logic [7:0][W-1:0] d, logic sob, logic eob, logic sof);
      bit e = 0;
      int st;
      beat_t b;
      if (sob) begin
         if (mcnt != 0) e = 1;
         mcnt = 0;
      end
      if (mcnt == 0) msof = sob && sof;
      rows[mcnt] = d;
      if (mcnt == 7) begin
         if (eob) begin
            st = (cyc + 1 > next_free) ? cyc + 1 : next_free;
            for (int j = 0; j < 8; j++) begin
               b.due = st + j;
               for (int i = 0; i < 8; i++) b.d[i] = rows[i][j];
               b.sob = (j == 0);
               b.eob = (j == 7);
               b.sof = (j == 0) && msof;
               q.push_back(b);
            end
            next_free = st + 8;
         end else e = 1;
         mcnt = 0;
      end else if (eob) begin
         e = 1;
         mcnt = 0;
      end else mcnt++;
      if (e) err_at[cyc] = 1;
   endtask

   task automatic send(logic [7:0][W-1:0] d, logic sob, logic eob, logic sof);
      in_valid = 1'b1;
      in_data  = d;
      in_sob   = sob;
      in_eob   = eob;
      in_sof   = sof;
      @(posedge clk);
      #1;
      model_beat(d, sob, eob, sof);
      in_valid = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // base < 0 means random data; eob_at = -1 means no eob in the sequence
   task automatic rows_seq(int n, int eob_at, int gapmax, int base, bit sof);
      logic [7:0][W-1:0] d;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 8; j++) d[j] = (base < 0) ? W'($urandom) : W'(base + 16 * i + j);
         send(d, i == 0, i == eob_at, sof && i == 0);
         if (gapmax > 0) idle($urandom_range(gapmax, 0));
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk1("rst_valid", out_valid, 1'b0);
         chk1("rst_sob", out_sob, 1'b0);
         chk1("rst_eob", out_eob, 1'b0);
         chk1("rst_sof", out_sof, 1'b0);
         chk1("rst_err", out_err, 1'b0);
         chkd("rst_data", out_data, '0);
      end else begin
         ev = q.size() > 0 && q[0].due <= cyc;
         chk1("valid", out_valid, ev);
         if (ev) begin
            chkd("data", out_data, q[0].d);
            chk1("sob", out_sob, q[0].sob);
            chk1("eob", out_eob, q[0].eob);
            chk1("sof", out_sof, q[0].sof);
            void'(q.pop_front());
         end
         chk1("err", out_err, err_at.exists(cyc) != 0);
      end
   end

   initial begin
      idle(3);
      rst_n = 1'b1;
      idle(2);
      rows_seq(8, 7, 0, 0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk1("pin_c0_valid", out_valid, 1'b1);
      chk1("pin_c0_sob", out_sob, 1'b1);
      chkd("pin_c0_lane3", {112'd0, out_data[3]}, {112'd0, 16'h0030});
      repeat (7) @(negedge clk);
      #1;
      chkd("pin_c7_lane2", {112'd0, out_data[2]}, {112'd0, 16'h0027});
      chk1("pin_c7_eob", out_eob, 1'b1);
      idle(3);
      for (int b = 0; b < 3; b++) rows_seq(8, 7, 0, 'h100 * (b + 1), b == 0);
      idle(12);
      rows_seq(8, 7, 5, -1, 1'b1);
      idle(12);
      rows_seq(4, -1, 0, 'h300, 1'b0);
      rows_seq(8, 7, 0, 'h400, 1'b1);
      idle(10);
      rows_seq(8, -1, 0, 'h500, 1'b0);
      chk1("pin_eob_missing_err", out_err, 1'b1);
      idle(3);
      rows_seq(6, 5, 0, 'h600, 1'b0);
      chk1("pin_eob_early_err", out_err, 1'b1);
      idle(12);
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(5, 0))
            0:       rows_seq($urandom_range(6, 1), -1, 1, -1, 1'b0);
            1:       rows_seq(8, -1, 1, -1, 1'b1);
            2:       rows_seq(6, 5, 1, -1, 1'b0);
            default: rows_seq(8, 7, $urandom_range(2, 0), -1, $urandom_range(1, 0) != 0);
         endcase
      end
      idle(12);
      rows_seq(8, 7, 0, 'h700, 1'b1);
      rows_seq(3, -1, 0, 'h800, 1'b0);
      idle(1);
      rst_n = 1'b0;
      q.delete();
      mcnt      = 0;
      next_free = 0;
      #1;
      chk1("pin_async_rst_valid", out_valid, 1'b0);
      chkd("pin_async_rst_data", out_data, '0);
      idle(3);
      rst_n = 1'b1;
      idle(1);
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) in_data[j] = W'('h900 + 16 * i + j);
         send(in_data, 1'b0, i == 7, 1'b0);
      end
      rows_seq(8, 7, 0, -1, 1'b1);
      idle(20);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected columns never appeared, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
